path_delay_line: RTL and testbench

- Clocked, synthesisable multi-channel model of a module path with separate rise (0->1) and fall (1->0) transition delays, counted in clock cycles.
- Each channel applies inertial delay: a pulse shorter than the applicable delay is rejected.
- Generalises a fixed two-terminal path delay to N_CH channels with run-time programmable delays.
- Used as a cycle-accurate delay-line stand-in for timing-path experiments next to the specify-block suite.

---
 rtl/path_delay_line_pkg.sv | 13 +
 rtl/path_delay_chan.sv | 85 ++++++++
 rtl/path_delay_line.sv | 74 +++++++
 tb/tb_path_delay_line.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/path_delay_line_pkg.sv
// Shared definitions for the multi-channel rise/fall inertial delay line.
// Holds the per-channel FSM encoding and the glitch-counter saturation value.
// No ports; imported by path_delay_chan and path_delay_line.
package path_delay_line_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } chan_state_t;

  localparam logic [15:0] GLITCH_MAX = 16'hFFFF;

endpackage

// File: rtl/path_delay_chan.sv
// One inertial-delay channel: FSM + down-counter + target bit, separate rise/fall delay.
// Latency: a held input change reaches o_q max(T,1) edges after it is first sampled.
// Backpressure: none; o_reject pulses combinationally on the edge a pending pulse collapses.
// Ports: i_clk, i_rst_n (sync, active-low), i_d, i_t_rise, i_t_fall -> o_q, o_busy, o_reject.
module path_delay_chan
  import path_delay_line_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_d,
  input  logic [CNT_W-1:0] i_t_rise,
  input  logic [CNT_W-1:0] i_t_fall,
  output logic             o_q,
  output logic             o_busy,
  output logic             o_reject
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  chan_state_t      r_state;
  chan_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tgt;
  logic             w_tgt_nxt;
  logic             r_q;
  logic             w_q_nxt;
  logic [CNT_W-1:0] w_t_sel;
  logic [CNT_W-1:0] w_cnt_start;

  // Delay is chosen by the direction of the new value; 0 and 1 both mean one edge.
  assign w_t_sel     = i_d ? i_t_rise : i_t_fall;
  assign w_cnt_start = (w_t_sel == '0) ? '0 : (w_t_sel - ONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tgt   <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
      r_q     <= w_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_q_nxt     = r_q;
    o_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_d != r_q) begin
          w_tgt_nxt   = i_d;
          w_cnt_nxt   = w_cnt_start;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (i_d != r_tgt) begin
          // Input went back to the output value before the delay elapsed.
          o_reject    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_q_nxt     = r_tgt;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_q    = r_q;
  assign o_busy = (r_state == ST_PEND);

endmodule

// File: rtl/path_delay_line.sv
// N_CH-channel clocked path delay with independent inertial rise/fall delays.
// Latency: max(T,1) edges from first sampled change to Q; Q/BUSY registered, no D->Q path.
// Backpressure: none. Optional PATH_DELAY_GLITCH_CNT_EN adds saturating GLITCH_CNT output.
// Ports: C (clock), RN (sync active-low reset), D, T_RISE, T_FALL -> Q, BUSY [, GLITCH_CNT].
module path_delay_line
  import path_delay_line_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic [N_CH-1:0]  D,
  input  logic [CNT_W-1:0] T_RISE,
  input  logic [CNT_W-1:0] T_FALL,
  output logic [N_CH-1:0]  Q,
  output logic [N_CH-1:0]  BUSY
`ifdef PATH_DELAY_GLITCH_CNT_EN
  ,
  output logic [15:0]      GLITCH_CNT
`endif
);

  logic [N_CH-1:0] w_q;
  logic [N_CH-1:0] w_busy;
  logic [N_CH-1:0] w_reject;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    path_delay_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .i_clk    (C),
      .i_rst_n  (RN),
      .i_d      (D[g]),
      .i_t_rise (T_RISE),
      .i_t_fall (T_FALL),
      .o_q      (w_q[g]),
      .o_busy   (w_busy[g]),
      .o_reject (w_reject[g])
    );
  end

  assign Q    = w_q;
  assign BUSY = w_busy;

`ifdef PATH_DELAY_GLITCH_CNT_EN
  logic [15:0] r_glitch_cnt;
  logic [16:0] w_glitch_sum;

  // One extra bit of headroom lets the saturation test be a simple compare.
  always_comb begin
    w_glitch_sum = {1'b0, r_glitch_cnt};
    for (int i = 0; i < N_CH; i++) begin
      w_glitch_sum = w_glitch_sum + 17'(w_reject[i]);
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch_sum > {1'b0, GLITCH_MAX}) begin
      r_glitch_cnt <= GLITCH_MAX;
    end else begin
      r_glitch_cnt <= w_glitch_sum[15:0];
    end
  end

  assign GLITCH_CNT = r_glitch_cnt;
`else
  logic w_unused_reject;
  assign w_unused_reject = ^w_reject;
`endif

endmodule

// File: tb/tb_path_delay_line.sv
// Directed-vector bench for path_delay_line with a queue-based scoreboard.
// The driver pushes the hand-computed Q/BUSY(/GLITCH_CNT) expected after each edge.
// A monitor pops one entry per edge and compares it with the DUT outputs.
module tb_path_delay_line;

  logic       C;
  logic       RN;
  logic [3:0] D;
  logic [7:0] T_RISE;
  logic [7:0] T_FALL;
  logic [3:0] Q;
  logic [3:0] BUSY;
`ifdef PATH_DELAY_GLITCH_CNT_EN
  logic [15:0] GLITCH_CNT;
`endif

  typedef struct {
    logic [3:0]  q;
    logic [3:0]  b;
    logic [15:0] g;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  path_delay_line #(
    .N_CH (4),
    .CNT_W(8)
  ) dut (
    .C     (C),
    .RN    (RN),
    .D     (D),
    .T_RISE(T_RISE),
    .T_FALL(T_FALL),
    .Q     (Q),
    .BUSY  (BUSY)
`ifdef PATH_DELAY_GLITCH_CNT_EN
    ,
    .GLITCH_CNT(GLITCH_CNT)
`endif
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Apply inputs for the next rising edge and record what must be seen after it.
  task automatic step(input logic rn, input logic [3:0] d, input logic [7:0] tr,
                      input logic [7:0] tf, input logic [3:0] eq, input logic [3:0] eb,
                      input logic [15:0] eg, input string tag);
    exp_t e;
    @(negedge C);
    RN     = rn;
    D      = d;
    T_RISE = tr;
    T_FALL = tf;
    e.q    = eq;
    e.b    = eb;
    e.g    = eg;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Monitor: outputs are registered, so check 1 time unit after each rising edge.
  always @(posedge C) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (Q !== e.q || BUSY !== e.b) begin
        n_fail++;
        $display("FAIL %s: got Q=%h BUSY=%h, expected Q=%h BUSY=%h", e.tag, Q, BUSY, e.q, e.b);
      end
`ifdef PATH_DELAY_GLITCH_CNT_EN
      n_tests++;
      if (GLITCH_CNT !== e.g) begin
        n_fail++;
        $display("FAIL %s glitch_cnt: got %h, expected %h", e.tag, GLITCH_CNT, e.g);
      end
`endif
    end
  end

  initial begin
    RN     = 1'b0;
    D      = 4'hF;
    T_RISE = 8'd3;
    T_FALL = 8'd5;

    // Reset with inputs high
    step(0, 4'hF, 3, 5, 4'h0, 4'h0, 0, "reset0");
    step(0, 4'hF, 3, 5, 4'h0, 4'h0, 0, "reset1");

    // Rise on all channels, T_RISE=3: Q changes on the third edge
    step(1, 4'hF, 3, 5, 4'h0, 4'hF, 0, "rise_start");
    step(1, 4'hF, 3, 5, 4'h0, 4'hF, 0, "rise_k1");
    step(1, 4'hF, 3, 5, 4'h0, 4'hF, 0, "rise_k2");
    step(1, 4'hF, 3, 5, 4'hF, 4'h0, 0, "rise_k3");

    // Fall on channel 0, T_FALL=5
    step(1, 4'hE, 3, 5, 4'hF, 4'h1, 0, "fall_start");
    step(1, 4'hE, 3, 5, 4'hF, 4'h1, 0, "fall_k1");
    step(1, 4'hE, 3, 5, 4'hF, 4'h1, 0, "fall_k2");
    step(1, 4'hE, 3, 5, 4'hF, 4'h1, 0, "fall_k3");
    step(1, 4'hE, 3, 5, 4'hF, 4'h1, 0, "fall_k4");
    step(1, 4'hE, 3, 5, 4'hE, 4'h0, 0, "fall_k5");

    // Two-cycle pulse against T_RISE=4 is rejected
    step(1, 4'hF, 4, 5, 4'hE, 4'h1, 0, "glitch_start");
    step(1, 4'hF, 4, 5, 4'hE, 4'h1, 0, "glitch_hold");
    step(1, 4'hE, 4, 5, 4'hE, 4'h0, 1, "glitch_reject");
    step(1, 4'hE, 4, 5, 4'hE, 4'h0, 1, "glitch_after");

    // T=0 and T=1 both give one edge of latency
    step(1, 4'hF, 0, 0, 4'hE, 4'h1, 1, "tr0_start");
    step(1, 4'hF, 0, 0, 4'hF, 4'h0, 1, "tr0_done");
    step(1, 4'hE, 0, 0, 4'hF, 4'h1, 1, "tf0_start");
    step(1, 4'hE, 0, 0, 4'hE, 4'h0, 1, "tf0_done");
    step(1, 4'hF, 1, 1, 4'hE, 4'h1, 1, "tr1_start");
    step(1, 4'hF, 1, 1, 4'hF, 4'h0, 1, "tr1_done");
    step(1, 4'hE, 1, 1, 4'hF, 4'h1, 1, "tf1_start");
    step(1, 4'hE, 1, 1, 4'hE, 4'h0, 1, "tf1_done");

    // Delay latched at start: T_RISE=6, changed to 1 mid-flight
    step(1, 4'hF, 6, 1, 4'hE, 4'h1, 1, "latch_k0");
    step(1, 4'hF, 6, 1, 4'hE, 4'h1, 1, "latch_k1");
    step(1, 4'hF, 1, 1, 4'hE, 4'h1, 1, "latch_k2");
    step(1, 4'hF, 1, 1, 4'hE, 4'h1, 1, "latch_k3");
    step(1, 4'hF, 1, 1, 4'hE, 4'h1, 1, "latch_k4");
    step(1, 4'hF, 1, 1, 4'hE, 4'h1, 1, "latch_k5");
    step(1, 4'hF, 1, 1, 4'hF, 4'h0, 1, "latch_k6");

    // All channels fall with T_FALL=2
    step(1, 4'h0, 2, 2, 4'hF, 4'hF, 1, "fall_all_k0");
    step(1, 4'h0, 2, 2, 4'hF, 4'hF, 1, "fall_all_k1");
    step(1, 4'h0, 2, 2, 4'h0, 4'h0, 1, "fall_all_k2");

    // Simultaneous rejection on all four channels
    step(1, 4'hF, 2, 2, 4'h0, 4'hF, 1, "multi_start");
    step(1, 4'h0, 2, 2, 4'h0, 4'h0, 5, "multi_reject");

    // Independent channels: ch0 rejected while ch2 completes
    step(1, 4'h5, 2, 2, 4'h0, 4'h5, 5, "mix_start");
    step(1, 4'h4, 2, 2, 4'h0, 4'h4, 6, "mix_rej0");
    step(1, 4'h4, 2, 2, 4'h4, 4'h0, 6, "mix_done2");

    // Reset while pending discards the pending change
    step(1, 4'hF, 5, 5, 4'h4, 4'hB, 6, "rstpend_start");
    step(1, 4'hF, 5, 5, 4'h4, 4'hB, 6, "rstpend_k1");
    step(0, 4'hF, 5, 5, 4'h0, 4'h0, 0, "rstpend_rst0");
    step(0, 4'h0, 5, 5, 4'h0, 4'h0, 0, "rstpend_rst1");
    for (int i = 0; i < 6; i++) begin
      step(1, 4'h0, 5, 5, 4'h0, 4'h0, 0, "rstpend_quiet");
    end

`ifdef PATH_DELAY_GLITCH_CNT_EN
    // Repeated four-channel glitches drive the counter into saturation
    begin
      int unsigned g_exp;
      g_exp = 0;
      for (int i = 0; i < 16400; i++) begin
        step(1, 4'hF, 2, 2, 4'h0, 4'hF, 16'(g_exp), "sat_start");
        g_exp = (g_exp + 4 > 32'hFFFF) ? 32'hFFFF : g_exp + 4;
        step(1, 4'h0, 2, 2, 4'h0, 4'h0, 16'(g_exp), "sat_reject");
      end
      step(1, 4'h0, 2, 2, 4'h0, 4'h0, 16'hFFFF, "sat_hold");
    end
`endif

    repeat (3) @(negedge C);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
